// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// -------------
// One-entry pipeline register with a single skid slot. The main register
// drives out_data directly. The skid register catches the one word that can
// arrive in the cycle where the consumer stops taking data. in_ready depends
// only on registered state, so the upstream handshake is never
// combinationally coupled to out_ready or stall.
//
// Parameters
//   WIDTH          payload width in bits (1..256)
//   CLEAR_ON_FLUSH 1: flush zeroes main and skid; 0: flush keeps their contents
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   flush      synchronous discard of every held entry; beats any transfer
//   stall      downstream hold; blocks out_fire while high
//   in_valid   upstream offers in_data
//   in_data    upstream payload
//   in_ready   stage can accept in_data this cycle (registered)
//   out_valid  out_data holds a valid entry (registered)
//   out_data   oldest held payload (registered)
//   out_ready  downstream accepts out_data
//
// Optional build macro PIPE_SKID_REG_PERF_EN adds two saturating counters:
//   stall_cnt  cycles in which a valid output was not transferred
//   flush_cnt  flush cycles that discarded a valid output
module pipe_skid_reg #(
    parameter int WIDTH          = 32,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
`ifdef PIPE_SKID_REG_PERF_EN
    ,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_d;
    logic             out_valid_d;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & ~stall;
    assign out_data = main_q;

    // State register. The handshake outputs get their own flops, loaded from
    // the next state, so both are pure register outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state and datapath enables. In ONE with both sides firing, the
    // consumer takes main while the new word replaces it, so occupancy stays
    // at one. in_fire cannot occur in FULL because in_ready is low there.
    // Flush is evaluated last so it overrides every transfer.
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (out_fire && !in_fire) begin
                    state_d = EMPTY;
                end else if (out_fire && in_fire) begin
                    load_main = 1'b1;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // Output decode of the next state, registered by the state register.
    always_comb begin
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Payload registers. Main keeps its last value while empty, so a drained
    // stage still shows the final word unless reset or a clearing flush hits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                main_q <= '0;
                skid_q <= '0;
            end
        end else begin
            if (main_from_skid) begin
                main_q <= skid_q;
            end else if (load_main) begin
                main_q <= in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef PIPE_SKID_REG_PERF_EN
    // Performance counters. Both saturate at 0xFFFF. A cycle counts as
    // stalled whenever a valid output is not transferred, whether stall or
    // a low out_ready is the cause.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !(out_ready && !stall) && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && out_valid && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
// ----------------
// Directed bench for pipe_skid_reg (WIDTH=32, CLEAR_ON_FLUSH=1). Inputs are
// driven 1 ns after a rising edge. Outputs are checked 1 ns after the next
// rising edge. Counter checks are built only when PIPE_SKID_REG_PERF_EN is
// defined.
module tb_pipe_skid_reg;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        stall;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
`ifdef PIPE_SKID_REG_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    int checks;
    int errors;

    pipe_skid_reg #(
        .WIDTH(32),
        .CLEAR_ON_FLUSH(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .flush(flush),
        .stall(stall),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready)
`ifdef PIPE_SKID_REG_PERF_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
`endif
    );

    // Free-running 10 ns clock. Rising edges occur at 5, 15, 25 ns and so on.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, then step to 1 ns past the next rising edge.
    task automatic applyStimulus(input logic v, input logic [31:0] d,
                                 input logic ordy, input logic st, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        stall     = st;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Directed sequence. Each block builds on the state left by the previous one.
    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state, sampled while reset is held.
        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_out_data", out_data, 32'h0);
`ifdef PIPE_SKID_REG_PERF_EN
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'h0);
        checkOutput("rst_flush_cnt", 32'(flush_cnt), 32'h0);
`endif
        rst = 1'b1;

        // Pass-through. The first word is accepted on the first edge after
        // reset is released.
        $display("[TB] pass-through");
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0, 1'b0);
        checkOutput("pt_data0", out_data, 32'h11);
        checkOutput("pt_valid0", 32'(out_valid), 32'h1);
        checkOutput("pt_ready0", 32'(in_ready), 32'h1);
        applyStimulus(1'b1, 32'h22, 1'b1, 1'b0, 1'b0);
        checkOutput("pt_data1", out_data, 32'h22);
        checkOutput("pt_ready1", 32'(in_ready), 32'h1);
        applyStimulus(1'b1, 32'h33, 1'b1, 1'b0, 1'b0);
        checkOutput("pt_data2", out_data, 32'h33);
        checkOutput("pt_ready2", 32'(in_ready), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("pt_drain_valid", 32'(out_valid), 32'h0);
        checkOutput("pt_hold_data", out_data, 32'h33);

        // Skid fill. The second word lands in skid. 0xEE is offered while the
        // stage is FULL and must never appear on the output.
        $display("[TB] skid fill");
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0);
        checkOutput("sk_data_a", out_data, 32'hA);
        applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0);
        checkOutput("sk_full_ready", 32'(in_ready), 32'h0);
        checkOutput("sk_full_valid", 32'(out_valid), 32'h1);
        checkOutput("sk_full_data", out_data, 32'hA);
        applyStimulus(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
        checkOutput("sk_hold_data", out_data, 32'hA);
        checkOutput("sk_hold_ready", 32'(in_ready), 32'h0);
        applyStimulus(1'b1, 32'hEE, 1'b1, 1'b0, 1'b0);
        checkOutput("sk_data_b", out_data, 32'hB);
        checkOutput("sk_ready_back", 32'(in_ready), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("sk_empty_valid", 32'(out_valid), 32'h0);
        checkOutput("sk_empty_data", out_data, 32'hB);
`ifdef PIPE_SKID_REG_PERF_EN
        // Two stalled cycles: the edge that loaded 0xB and the edge that held 0xEE.
        checkOutput("sk_stall_cnt", 32'(stall_cnt), 32'd2);
`endif

        // Stall. The edge that fills skid also counts, so the total becomes
        // 2 + 1 + 3 = 6.
        $display("[TB] stall");
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
            checkOutput("st_data", out_data, 32'h1);
            checkOutput("st_valid", 32'(out_valid), 32'h1);
            checkOutput("st_ready", 32'(in_ready), 32'h0);
        end
`ifdef PIPE_SKID_REG_PERF_EN
        checkOutput("st_stall_cnt", 32'(stall_cnt), 32'd6);
`endif

        // Flush while FULL, with stall high and 0xC offered. Flush wins and
        // 0xC is dropped. The same edge also counts as stalled, giving 7.
        $display("[TB] flush");
        applyStimulus(1'b1, 32'hC, 1'b1, 1'b1, 1'b1);
        checkOutput("fl_valid", 32'(out_valid), 32'h0);
        checkOutput("fl_data", out_data, 32'h0);
        checkOutput("fl_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            checkOutput("fl_no_emit", 32'(out_valid), 32'h0);
            checkOutput("fl_data_kept", out_data, 32'h0);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
`ifdef PIPE_SKID_REG_PERF_EN
        checkOutput("fl_flush_cnt", 32'(flush_cnt), 32'd1);
        checkOutput("fl_stall_cnt", 32'(stall_cnt), 32'd7);
`endif

        // Reset applied mid-cycle while in ONE takes effect before any edge.
        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 32'h55, 1'b0, 1'b0, 1'b0);
        checkOutput("rm_pre_data", out_data, 32'h55);
        checkOutput("rm_pre_valid", 32'(out_valid), 32'h1);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rm_valid", 32'(out_valid), 32'h0);
        checkOutput("rm_ready", 32'(in_ready), 32'h1);
        checkOutput("rm_data", out_data, 32'h0);
`ifdef PIPE_SKID_REG_PERF_EN
        checkOutput("rm_stall_cnt", 32'(stall_cnt), 32'h0);
        checkOutput("rm_flush_cnt", 32'(flush_cnt), 32'h0);
`endif
        #2;
        rst = 1'b1;
        applyStimulus(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        checkOutput("rm_after_data", out_data, 32'h66);
        checkOutput("rm_after_valid", 32'(out_valid), 32'h1);

`ifdef PIPE_SKID_REG_PERF_EN
        // Saturation. The stage holds 0x66 in ONE with out_ready low, so every
        // cycle counts: 65534 cycles give FFFE, one more gives FFFF, and the
        // count then stays at FFFF for the rest of the 70000 cycles.
        $display("[TB] saturation");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        repeat (65533) @(posedge clk);
        #1;
        checkOutput("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checkOutput("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        repeat (4465) @(posedge clk);
        #1;
        checkOutput("sat_hold", 32'(stall_cnt), 32'hFFFF);
        checkOutput("sat_data", out_data, 32'h66);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
